// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the serial sequence detector family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t {IDLE, SHIFT}; WIDTH_DEF / IDLE_LEVEL_DEF, which the
// detector and its bench also use.
package seq_det_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int   WIDTH_DEF      = 8;
   localparam logic IDLE_LEVEL_DEF = 1'b0;

endpackage

// File: rtl/seq_det_serializer.sv
// Parallel-to-serial front end feeding the sequence detector's serial input B.
// Latency: first bit on B one clock after the handshake edge, last bit WIDTH clocks after.
// Backpressure: Load_ready only in IDLE or on the last bit; Hold freezes everything and blocks loads.
// Ports: Clk/Rst (async, active-low); Data_in/Load_valid/Load_ready load handshake;
//        Hold stall; B/B_valid/B_last registered serial output; Busy = word in flight.
module seq_det_serializer
   import seq_det_pkg::*;
#(
   parameter int   WIDTH      = WIDTH_DEF,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] Data_in,
   input  logic             Load_valid,
   output logic             Load_ready,
   input  logic             Hold,
   output logic             B,
   output logic             B_valid,
   output logic             B_last,
   output logic             Busy
);

   localparam int             CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             b_q, b_d;
   logic             b_valid_q, b_valid_d;
   logic             b_last_q, b_last_d;
   logic             xfer;

   // Bit that sits at the output end of a word.
   function automatic logic out_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Move the next bit into the output position.
   function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   // Ready either when idle or while the last bit is on B, so the next word
   // follows with no gap. Gating by Rst keeps it low throughout reset.
   assign Load_ready = Rst && !Hold &&
                       (state_q == IDLE || (state_q == SHIFT && cnt_q == CNT_LAST));
   assign xfer       = Load_valid && Load_ready;

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      b_d       = b_q;
      b_valid_d = b_valid_q;
      b_last_d  = b_last_q;

      // Hold leaves every default in place; xfer is already blocked by Load_ready.
      if (!Hold) begin
         if (xfer) begin
            // Same action from IDLE or from the last bit of SHIFT: start a new word.
            state_d   = SHIFT;
            sr_d      = Data_in;
            cnt_d     = '0;
            b_d       = out_bit(Data_in);
            b_valid_d = 1'b1;
            b_last_d  = (CNT_LAST == '0);
         end else if (state_q == SHIFT) begin
            if (cnt_q != CNT_LAST) begin
               sr_d      = shift_word(sr_q);
               cnt_d     = cnt_q + CNT_W'(1);
               b_d       = out_bit(sr_d);
               b_valid_d = 1'b1;
               b_last_d  = (cnt_d == CNT_LAST);
            end else begin
               state_d   = IDLE;
               b_d       = IDLE_LEVEL;
               b_valid_d = 1'b0;
               b_last_d  = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         b_q       <= IDLE_LEVEL;
         b_valid_q <= 1'b0;
         b_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         b_q       <= b_d;
         b_valid_q <= b_valid_d;
         b_last_q  <= b_last_d;
      end
   end

   assign B       = b_q;
   assign B_valid = b_valid_q;
   assign B_last  = b_last_q;
   assign Busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_seq_det_serializer.sv
// Bench for seq_det_serializer: one MSB-first and one LSB-first instance share stimulus.
// Reference model is a queue of pending {last, bit} items per instance; its front is what B shows.
// Directed scenarios use literal bit sequences; the random scenario uses the queue model.
module tb_seq_det_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] data_in;
   logic         load_valid;
   logic         hold;

   logic m_rdy, m_b, m_bv, m_bl, m_busy;
   logic l_rdy, l_b, l_bv, l_bl, l_busy;

   int checks = 0;
   int errors = 0;

   logic [1:0] qm[$];   // {last, bit} pending on MSB-first instance
   logic [1:0] ql[$];   // same for LSB-first instance

   always #5 clk = ~clk;

   seq_det_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
      .Clk(clk), .Rst(rst), .Data_in(data_in), .Load_valid(load_valid),
      .Load_ready(m_rdy), .Hold(hold), .B(m_b), .B_valid(m_bv),
      .B_last(m_bl), .Busy(m_busy));

   seq_det_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
      .Clk(clk), .Rst(rst), .Data_in(data_in), .Load_valid(load_valid),
      .Load_ready(l_rdy), .Hold(hold), .B(l_b), .B_valid(l_bv),
      .B_last(l_bl), .Busy(l_busy));

   // Drive inputs at a falling edge, advance the model on the rising edge,
   // return at the next falling edge where outputs are stable.
   task automatic tick(input logic v, input logic [W-1:0] d, input logic h);
      logic hs;
      load_valid = v;
      data_in    = d;
      hold       = h;
      @(posedge clk);
      if (!rst) begin
         qm.delete();
         ql.delete();
      end else if (!h) begin
         hs = v && (qm.size() <= 1);
         if (qm.size() > 0) qm.delete(0);
         if (ql.size() > 0) ql.delete(0);
         if (hs) begin
            for (int i = 0; i < W; i++) begin
               qm.push_back({(i == W - 1), d[W-1-i]});
               ql.push_back({(i == W - 1), d[i]});
            end
         end
      end
      @(negedge clk);
   endtask

   // Expected {B, B_valid, B_last, Busy} from the model queue.
   function automatic logic [3:0] exp_out(input bit lsb);
      logic [1:0] f;
      if (lsb ? (ql.size() == 0) : (qm.size() == 0)) return 4'b0000;
      f = lsb ? ql[0] : qm[0];
      return {f[0], 1'b1, f[1], 1'b1};
   endfunction

   function automatic logic exp_ready(input logic h);
      return rst && !h && (qm.size() <= 1);
   endfunction

   task automatic test_reset();
      rst = 1'b0; load_valid = 1'b0; hold = 1'b0; data_in = '0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({m_b, m_bv, m_bl, m_busy, m_rdy, l_b, l_bv, l_bl, l_busy, l_rdy} !== 10'b0) begin
         errors++;
         $display("FAIL reset_state: got %b %b required all zero",
                  {m_b, m_bv, m_bl, m_busy, m_rdy}, {l_b, l_bv, l_bl, l_busy, l_rdy});
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({m_rdy, l_rdy} !== 2'b11) begin
         errors++;
         $display("FAIL reset_release_ready: got %b required 11", {m_rdy, l_rdy});
      end
      @(negedge clk);
   endtask

   task automatic test_single_word();
      logic [7:0] seq_m = 8'b1011_0101;   // first bit at [7]
      logic [7:0] seq_l = 8'b1010_1101;   // first bit at [7]
      tick(1'b1, 8'hB5, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({m_b, m_bv, m_bl, m_busy} !== {seq_m[7-i], 1'b1, (i == 7), 1'b1}) begin
            errors++;
            $display("FAIL single_msb[%0d]: got %b required %b", i,
                     {m_b, m_bv, m_bl, m_busy}, {seq_m[7-i], 1'b1, (i == 7), 1'b1});
         end
         checks++;
         if ({l_b, l_bv, l_bl, l_busy} !== {seq_l[7-i], 1'b1, (i == 7), 1'b1}) begin
            errors++;
            $display("FAIL single_lsb[%0d]: got %b required %b", i,
                     {l_b, l_bv, l_bl, l_busy}, {seq_l[7-i], 1'b1, (i == 7), 1'b1});
         end
         // Data_in wiggling without a handshake must not matter.
         tick(1'b0, W'($urandom), 1'b0);
      end
      checks++;
      if ({m_b, m_bv, m_bl, m_busy, m_rdy} !== 5'b00001) begin
         errors++;
         $display("FAIL single_idle: got %b required 00001", {m_b, m_bv, m_bl, m_busy, m_rdy});
      end
   endtask

   task automatic test_back_to_back();
      logic v;
      tick(1'b1, 8'hFF, 1'b0);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if ({m_b, m_bv, m_bl} !== {(i < 8), 1'b1, (i == 7 || i == 15)}) begin
            errors++;
            $display("FAIL b2b_out[%0d]: got %b required %b", i,
                     {m_b, m_bv, m_bl}, {(i < 8), 1'b1, (i == 7 || i == 15)});
         end
         v = (i < 8);
         load_valid = v; data_in = 8'h00; hold = 1'b0;
         #1;
         checks++;
         if (m_rdy !== (i == 7 || i == 15)) begin
            errors++;
            $display("FAIL b2b_ready[%0d]: got %b required %b", i, m_rdy, (i == 7 || i == 15));
         end
         tick(v, 8'h00, 1'b0);
      end
      checks++;
      if ({m_bv, m_busy, l_bv, l_busy} !== 4'b0000) begin
         errors++;
         $display("FAIL b2b_idle: got %b required 0000", {m_bv, m_busy, l_bv, l_busy});
      end
   endtask

   task automatic test_hold();
      logic [5:0] rest = 6'b100000;   // bits 3..8 of 8'hE0, first at [5]
      tick(1'b1, 8'hE0, 1'b0);
      tick(1'b0, 8'h00, 1'b0);        // second bit now on B
      for (int k = 0; k < 3; k++) begin
         load_valid = 1'b1; hold = 1'b1; data_in = 8'h3C;
         #1;
         checks++;
         if ({m_rdy, l_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL hold_ready[%0d]: got %b required 00", k, {m_rdy, l_rdy});
         end
         tick(1'b1, 8'h3C, 1'b1);
         checks++;
         if ({m_b, m_bv, m_bl, m_busy} !== 4'b1101 || {l_b, l_bv, l_bl, l_busy} !== exp_out(1)) begin
            errors++;
            $display("FAIL hold_freeze[%0d]: got %b %b required 1101 %b", k,
                     {m_b, m_bv, m_bl, m_busy}, {l_b, l_bv, l_bl, l_busy}, exp_out(1));
         end
      end
      for (int j = 0; j < 6; j++) begin
         tick(1'b0, 8'h00, 1'b0);
         checks++;
         if ({m_b, m_bv, m_bl, m_busy} !== {rest[5-j], 1'b1, (j == 5), 1'b1}) begin
            errors++;
            $display("FAIL hold_rest[%0d]: got %b required %b", j,
                     {m_b, m_bv, m_bl, m_busy}, {rest[5-j], 1'b1, (j == 5), 1'b1});
         end
      end
      // Hold on the last bit, with the next word already offered.
      for (int k = 0; k < 2; k++) begin
         load_valid = 1'b1; hold = 1'b1; data_in = 8'h96;
         #1;
         checks++;
         if (m_rdy !== 1'b0) begin
            errors++;
            $display("FAIL hold_last_ready[%0d]: got %b required 0", k, m_rdy);
         end
         tick(1'b1, 8'h96, 1'b1);
         checks++;
         if ({m_b, m_bv, m_bl, m_busy} !== 4'b0111) begin
            errors++;
            $display("FAIL hold_last_out[%0d]: got %b required 0111", k, {m_b, m_bv, m_bl, m_busy});
         end
      end
      load_valid = 1'b1; hold = 1'b0;
      #1;
      checks++;
      if (m_rdy !== 1'b1) begin
         errors++;
         $display("FAIL hold_release_ready: got %b required 1", m_rdy);
      end
      tick(1'b1, 8'h96, 1'b0);
      checks++;
      if ({m_b, m_bl, l_b, l_bl} !== 4'b1000) begin
         errors++;
         $display("FAIL hold_next_first: got %b required 1000", {m_b, m_bl, l_b, l_bl});
      end
      for (int k = 0; k < 8; k++) tick(1'b0, 8'h00, 1'b0);
      // Hold while idle: loads blocked, outputs stay idle.
      load_valid = 1'b1; hold = 1'b1; data_in = 8'hFF;
      #1;
      checks++;
      if (m_rdy !== 1'b0) begin
         errors++;
         $display("FAIL hold_idle_ready: got %b required 0", m_rdy);
      end
      tick(1'b1, 8'hFF, 1'b1);
      checks++;
      if ({m_b, m_bv, m_bl, m_busy} !== 4'b0000) begin
         errors++;
         $display("FAIL hold_idle_out: got %b required 0000", {m_b, m_bv, m_bl, m_busy});
      end
      tick(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_reset_mid_word();
      logic [7:0] seq_m = 8'b0000_0111;   // first bit at [7]
      logic [2:0] hist = 3'b000;
      int         det = 0;
      tick(1'b1, 8'hFF, 1'b0);
      tick(1'b0, 8'h00, 1'b0);
      tick(1'b0, 8'h00, 1'b0);        // third bit on B
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({m_b, m_bv, m_bl, m_busy, m_rdy, l_b, l_bv, l_bl, l_busy, l_rdy} !== 10'b0) begin
         errors++;
         $display("FAIL reset_mid_word: got %b %b required all zero",
                  {m_b, m_bv, m_bl, m_busy, m_rdy}, {l_b, l_bv, l_bl, l_busy, l_rdy});
      end
      @(negedge clk);
      tick(1'b0, 8'h00, 1'b0);        // edge while in reset: model drops everything
      rst = 1'b1;
      tick(1'b1, 8'h07, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if ({m_b, m_bv, m_bl} !== {seq_m[7-i], 1'b1, (i == 7)} ||
             {l_b, l_bv, l_bl, l_busy} !== exp_out(1)) begin
            errors++;
            $display("FAIL after_reset[%0d]: got %b %b required %b %b", i,
                     {m_b, m_bv, m_bl}, {l_b, l_bv, l_bl, l_busy},
                     {seq_m[7-i], 1'b1, (i == 7)}, exp_out(1));
         end
         if (m_bv) begin
            hist = {hist[1:0], m_b};
            if (hist == 3'b111) det++;
         end
         tick(1'b0, 8'h00, 1'b0);
      end
      checks++;
      if (det !== 1) begin
         errors++;
         $display("FAIL detector_111_count: got %0d required 1", det);
      end
   endtask

   task automatic test_random();
      logic         v, h;
      logic [W-1:0] d;
      for (int c = 0; c < 600; c++) begin
         v = ($urandom_range(99) < 70);
         h = ($urandom_range(99) < 15);
         d = W'($urandom);
         load_valid = v; hold = h; data_in = d;
         #1;
         checks++;
         if ({m_rdy, l_rdy} !== {2{exp_ready(h)}}) begin
            errors++;
            $display("FAIL rand_ready[%0d]: got %b required %b", c, {m_rdy, l_rdy}, {2{exp_ready(h)}});
         end
         tick(v, d, h);
         checks++;
         if ({m_b, m_bv, m_bl, m_busy} !== exp_out(0) || {l_b, l_bv, l_bl, l_busy} !== exp_out(1)) begin
            errors++;
            $display("FAIL rand_out[%0d]: got %b %b required %b %b", c,
                     {m_b, m_bv, m_bl, m_busy}, {l_b, l_bv, l_bl, l_busy}, exp_out(0), exp_out(1));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_hold();
      test_reset_mid_word();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_det_serializer.md
# seq_det_serializer

Parallel-to-serial front end for the serial sequence detector. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on `B`, the detector's serial input. It also provides a qualifying strobe, a last-bit marker and a stall input. Words can be issued back-to-back with no idle gap, so the detector sees a continuous bit stream across word boundaries.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = `Data_in[WIDTH-1]` is sent first; 0 = `Data_in[0]` is sent first.
- `IDLE_LEVEL`, 0: value driven on `B` when no bit is valid.

Ports:
- `Clk`, input, 1: single clock, rising-edge.
- `Rst`, input, 1: asynchronous, active-low reset (0 = reset).
- `Data_in`, input, WIDTH: word to serialize, sampled on handshake.
- `Load_valid`, input, 1: `Data_in` is valid.
- `Load_ready`, output, 1: block can accept a word this cycle.
- `Hold`, input, 1: stall; freezes all state while 1.
- `B`, output, 1: serial bit to the detector (registered).
- `B_valid`, output, 1: `B` carries a data bit (registered).
- `B_last`, output, 1: `B` is the final bit of the current word (registered).
- `Busy`, output, 1: a word is in flight (state SHIFT).

## Operation
- States: IDLE, SHIFT.
- Storage: WIDTH-bit shift register `sr`, and bit counter `cnt` of width $clog2(WIDTH).
- Handshake: a transfer occurs on a rising edge where `Load_valid && Load_ready`. Data is never dropped or duplicated.
- `Load_ready = Rst && !Hold && (state==IDLE || (state==SHIFT && cnt==WIDTH-1))`. It is combinational.
- IDLE, transfer: load `sr` from `Data_in`, set `cnt` to 0, go to SHIFT. On the next cycle `B` is the first bit.
- SHIFT, `cnt < WIDTH-1`: shift `sr` toward the output end (left if MSB_FIRST, otherwise right) and increment `cnt`.
- SHIFT, `cnt == WIDTH-1` (last bit on `B`):
  - With a transfer: reload `sr` from `Data_in`, set `cnt` to 0 and stay in SHIFT. The first bit of the new word follows with no gap.
  - Without a transfer: go to IDLE.
- Outputs, all registered:
  - In SHIFT: `B` = current output bit of `sr`, `B_valid` = 1, `B_last` = (`cnt == WIDTH-1`).
  - In IDLE: `B` = IDLE_LEVEL, `B_valid` = 0, `B_last` = 0.
- `Busy` = (state==SHIFT).
- Hold: while `Hold` = 1, `state`, `sr`, `cnt`, `B`, `B_valid` and `B_last` keep their values, and `Load_ready` = 0. Shifting resumes on the first edge with `Hold` = 0.
- `Data_in` changes while not handshaking have no effect.

## Timing
- Reset values, forced asynchronously while `Rst` = 0:
  - state = IDLE, `sr` = 0, `cnt` = 0.
  - `B` = IDLE_LEVEL, `B_valid` = 0, `B_last` = 0, `Busy` = 0, `Load_ready` = 0.
- Release of `Rst`: `Load_ready` rises combinationally once `Rst` = 1 (with `Hold` = 0).
- Latency: the first bit appears on `B` (with `B_valid` = 1) one clock after the handshake edge. The last bit appears WIDTH clocks after the handshake edge.
- Each bit is held on `B` for exactly one clock unless `Hold` is asserted.
- Throughput: one word per WIDTH clocks when `Load_valid` is held high.
- Reset mid-word: the word is aborted immediately and not resumed. `B` returns to IDLE_LEVEL in the same instant.
- Simultaneous `Hold` and `Load_valid`: no transfer occurs, because `Load_ready` = 0.
- Hold on the last bit: `B_last` stays 1 for the whole hold. The handshake for the next word waits until `Hold` drops.
- Hold in IDLE: no effect on outputs. Loads are blocked.

## Structure
- Shared package `seq_det_pkg`:
  - State enum {IDLE, SHIFT}.
  - Default constants WIDTH_DEF = 8 and IDLE_LEVEL_DEF = 0, shared with the detector and its bench.
- No sub-module. The shift register, counter and two-state FSM are coded inline; expected size is about 150 lines.

## Test plan
All scenarios use WIDTH = 8.
- Reset check: assert `Rst` = 0 mid-run → `B` = 0, `B_valid` = 0, `B_last` = 0, `Busy` = 0 and `Load_ready` = 0 immediately, with no clock edge needed.
- Single word, MSB_FIRST = 1: load 8'hB5 → `B` = 1,0,1,1,0,1,0,1 on the 8 clocks after the handshake. `B_last` is 1 only on the 8th clock. Return to IDLE follows.
- LSB_FIRST (MSB_FIRST = 0): load 8'hB5 → `B` = 1,0,1,0,1,1,0,1.
- Back-to-back words: `Load_valid` held high with 8'hFF then 8'h00 → 16 contiguous valid bits (eight 1s, then eight 0s). `Load_ready` pulses high on the two last-bit cycles. `B_valid` never drops between the words.
- Hold: load 8'hE0 and assert `Hold` for 3 clocks while the 2nd bit is on `B` → `B` stays 1 for 4 clocks total. The remaining bits are 1,0,0,0,0,0 and the word completes 3 clocks late.
- Reset mid-word, then detector feed: abort 8'hFF after 3 bits, then load 8'h07 → the output contains no remnant of 8'hFF. `B` is 0,0,0,0,0,1,1,1, and the downstream detector sees its 111 pattern only from the new word.
